// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_pkg
//  Description : Shared constants and types for the raster timing generator.
//                Pattern-select codes, FSM state encodings, default timing
//                constants and the colour-bar lookup.
//  Revision    : 1.0  initial release
// ============================================================================
package video_timing_pkg;

    // Pattern select codes
    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_BARS  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // Generator FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Default timing totals for the standard configuration
    localparam int DEF_HTOT = 15;
    localparam int DEF_HACT = 10;

    // Colour-bar {R,G,B} on/off masks, bar 0 in the low bits:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_COLOURS = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};

    // Expands a bar index into a full 30-bit {R,G,B} pixel
    function automatic logic [29:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] m;
        m = BAR_COLOURS[idx*3 +: 3];
        return {{10{m[2]}}, {10{m[1]}}, {10{m[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_pattern_gen
//  Description : Maps active coordinates and the latched pattern selection to
//                a registered 30-bit {R,G,B} pixel. Output is zero whenever
//                i_de is low.
//  Ports       : clk, rst        clock / async active-high reset
//                i_de            active-pixel qualifier for this clock
//                i_x, i_y        active coordinates
//                i_pat           latched pattern select
//                i_solid         latched solid colour
//                o_rgb           registered pixel {R,G,B}
//  Revision    : 1.0  initial release
// ============================================================================
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int HW       = 4,
    parameter int VW       = 4,
    parameter int HACT     = DEF_HACT,
    parameter int CHK_LOG2 = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_de,
    input  logic [HW-1:0] i_x,
    input  logic [VW-1:0] i_y,
    input  logic [1:0]    i_pat,
    input  logic [29:0]   i_solid,
    output logic [29:0]   o_rgb
);

    // Bar width is HACT/8, never less than one pixel
    localparam int BAR_W = (HACT >= 8) ? (HACT / 8) : 1;
    localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BCW-1:0] C_BAR_LAST = BCW'(BAR_W - 1);

    logic [9:0]     w_x10;
    logic           w_chk;
    logic [2:0]     r_bar_idx;
    logic [BCW-1:0] r_bar_cnt;
    logic [29:0]    r_rgb;

    // Ramp value: x zero-extended or truncated to 10 bits
    if (HW >= 10) begin : g_x_trunc
        assign w_x10 = i_x[9:0];
    end else begin : g_x_ext
        assign w_x10 = {{(10 - HW){1'b0}}, i_x};
    end

    assign w_chk = (|((i_x >> CHK_LOG2) & HW'(1))) ^ (|((i_y >> CHK_LOG2) & VW'(1)));

    // Bar index tracks the current pixel: restarts at each line's blanking,
    // steps every BAR_W active pixels and saturates on the last (black) bar.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bar_idx <= 3'd0;
            r_bar_cnt <= '0;
        end else if (!i_de) begin
            r_bar_idx <= 3'd0;
            r_bar_cnt <= '0;
        end else if (r_bar_cnt == C_BAR_LAST) begin
            r_bar_cnt <= '0;
            if (r_bar_idx != 3'd7) begin
                r_bar_idx <= r_bar_idx + 3'd1;
            end
        end else begin
            r_bar_cnt <= r_bar_cnt + BCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (!i_de) begin
            r_rgb <= '0;
        end else begin
            case (i_pat)
                PAT_SOLID: r_rgb <= i_solid;
                PAT_RAMP:  r_rgb <= {w_x10, w_x10, w_x10};
                PAT_BARS:  r_rgb <= bar_rgb(r_bar_idx);
                default:   r_rgb <= w_chk ? 30'h3FFF_FFFF : 30'h0;
            endcase
        end
    end

    assign o_rgb = r_rgb;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing and test-pattern source. Generates registered
//                vsync/hsync/de plus 30-bit RGB pixels; frames start and stop
//                only on frame boundaries.
//  Ports       : clk, rst              pixel clock / async active-high reset
//                i_en                  run request
//                i_pat_sel, i_solid_rgb pattern select and solid colour
//                o_vsync, o_hsync, o_de timing outputs (1-clock latency)
//                o_r/g/b_data          pixel channels, 0 outside o_de
//                o_sof                 pulse on first vsync clock of a frame
//                o_busy                high while running or stopping
//                o_frame_cnt           completed frame count (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int HSW      = 1,
    parameter int HBP      = 2,
    parameter int HACT     = 10,
    parameter int HFP      = 2,
    parameter int VSW      = 1,
    parameter int VBP      = 1,
    parameter int VACT     = 8,
    parameter int VFP      = 1,
    parameter int CHK_LOG2 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [1:0]  i_pat_sel,
    input  logic [29:0] i_solid_rgb,
    output logic        o_vsync,
    output logic        o_hsync,
    output logic        o_de,
    output logic [9:0]  o_r_data,
    output logic [9:0]  o_g_data,
    output logic [9:0]  o_b_data,
    output logic        o_sof,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    localparam int HTOT = HSW + HBP + HACT + HFP;
    localparam int VTOT = VSW + VBP + VACT + VFP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);

    localparam logic [HW-1:0] C_H_LAST  = HW'(HTOT - 1);
    localparam logic [HW-1:0] C_HSW     = HW'(HSW);
    localparam logic [HW-1:0] C_HA_BEG  = HW'(HSW + HBP);
    localparam logic [HW-1:0] C_HA_END  = HW'(HSW + HBP + HACT);
    localparam logic [VW-1:0] C_V_LAST  = VW'(VTOT - 1);
    localparam logic [VW-1:0] C_VSW     = VW'(VSW);
    localparam logic [VW-1:0] C_VA_BEG  = VW'(VSW + VBP);
    localparam logic [VW-1:0] C_VA_END  = VW'(VSW + VBP + VACT);

    state_t        r_state, w_state_nxt;
    logic          w_latch;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [1:0]    r_pat;
    logic [29:0]   r_solid;
    logic [15:0]   r_frame_cnt;
    logic          r_hsync, r_vsync, r_de, r_sof;
    logic [29:0]   w_rgb;

    logic          w_running, w_h_last, w_frame_end;
    logic          w_hsync, w_vsync, w_de;
    logic [HW-1:0] w_x;
    logic [VW-1:0] w_y;

    assign w_running   = (r_state != ST_IDLE);
    assign w_h_last    = (r_h_cnt == C_H_LAST);
    assign w_frame_end = w_h_last && (r_v_cnt == C_V_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_latch marks the clocks where a new frame begins in RUN; the pattern
    // selection is captured only there so mid-frame changes are deferred.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_nxt = ST_RUN;
                    w_latch     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_frame_end) begin
                    if (i_en) begin
                        w_latch = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!i_en) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (i_en) begin
                    // Resume the current frame; no restart
                    w_state_nxt = ST_RUN;
                    w_latch     = w_frame_end;
                end else if (w_frame_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Counters and pattern latch ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_running) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= PAT_SOLID;
            r_solid <= '0;
        end else if (w_latch) begin
            r_pat   <= i_pat_sel;
            r_solid <= i_solid_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_running && w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // ---------------- Timing decode ----------------
    assign w_hsync = (r_h_cnt < C_HSW);
    assign w_vsync = (r_v_cnt < C_VSW);
    assign w_de    = (r_h_cnt >= C_HA_BEG) && (r_h_cnt < C_HA_END) &&
                     (r_v_cnt >= C_VA_BEG) && (r_v_cnt < C_VA_END);
    assign w_x     = r_h_cnt - C_HA_BEG;
    assign w_y     = r_v_cnt - C_VA_BEG;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
            r_de    <= 1'b0;
            r_sof   <= 1'b0;
        end else begin
            r_hsync <= w_running && w_hsync;
            r_vsync <= w_running && w_vsync;
            r_de    <= w_running && w_de;
            r_sof   <= w_running && (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    video_pattern_gen #(
        .HW       (HW),
        .VW       (VW),
        .HACT     (HACT),
        .CHK_LOG2 (CHK_LOG2)
    ) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .i_de    (w_running && w_de),
        .i_x     (w_x),
        .i_y     (w_y),
        .i_pat   (r_pat),
        .i_solid (r_solid),
        .o_rgb   (w_rgb)
    );

    assign o_hsync     = r_hsync;
    assign o_vsync     = r_vsync;
    assign o_de        = r_de;
    assign o_sof       = r_sof;
    assign o_r_data    = w_rgb[29:20];
    assign o_g_data    = w_rgb[19:10];
    assign o_b_data    = w_rgb[9:0];
    assign o_busy      = w_running;
    assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Directed self-checking bench for video_timing_gen with the
//                default 15x11 raster (HSW1 HBP2 HACT10 HFP2 / VSW1 VBP1
//                VACT8 VFP1). Index t counts frame clocks from the first
//                hsync/vsync output of a frame: de when h=t%15 in [3,13) and
//                v=t/15 in [2,10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int HTOT  = 15;
    localparam int FRAME = 165;
    localparam logic [29:0] WHITE = 30'h3FFF_FFFF;
    localparam logic [29:0] SOLID = 30'h155A_A155;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [1:0]  i_pat_sel;
    logic [29:0] i_solid_rgb;
    logic        o_vsync, o_hsync, o_de, o_sof, o_busy;
    logic [9:0]  o_r_data, o_g_data, o_b_data;
    logic [15:0] o_frame_cnt;

    int checks   = 0;
    int failures = 0;

    logic        cap_hs   [FRAME];
    logic        cap_vs   [FRAME];
    logic        cap_de   [FRAME];
    logic        cap_sof  [FRAME];
    logic        cap_busy [FRAME];
    logic [29:0] cap_rgb  [FRAME];
    logic [15:0] cap_fc   [FRAME];

    // Hand-derived colour bars for x = 0..9 (bar width 1)
    logic [29:0] bar_exp [10] = '{30'h3FFF_FFFF, 30'h3FFF_FC00, 30'h000F_FFFF,
                                  30'h000F_FC00, 30'h3FF0_03FF, 30'h3FF0_0000,
                                  30'h0000_03FF, 30'h0, 30'h0, 30'h0};
    // Checker row 0: 0,0,W,W,0,0,W,W,0,0
    logic        chk_row0 [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                   1'b1, 1'b1, 1'b0, 1'b0};

    video_timing_gen dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_pat_sel   (i_pat_sel),
        .i_solid_rgb (i_solid_rgb),
        .o_vsync     (o_vsync),
        .o_hsync     (o_hsync),
        .o_de        (o_de),
        .o_r_data    (o_r_data),
        .o_g_data    (o_g_data),
        .o_b_data    (o_b_data),
        .o_sof       (o_sof),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit exp_de(input int t);
        int h = t % HTOT;
        int v = t / HTOT;
        return (h >= 3) && (h < 13) && (v >= 2) && (v < 10);
    endfunction

    // Records one frame of outputs from the current sample point (t=0) and
    // applies optional input changes at given frame clocks (-1 = none).
    task automatic walk_frame(input int off_t, input int on_t, input int pat_t,
                              input logic [1:0] npat, input logic [29:0] nsolid);
        for (int t = 0; t < FRAME; t++) begin
            cap_hs[t]   = o_hsync;
            cap_vs[t]   = o_vsync;
            cap_de[t]   = o_de;
            cap_sof[t]  = o_sof;
            cap_busy[t] = o_busy;
            cap_rgb[t]  = {o_r_data, o_g_data, o_b_data};
            cap_fc[t]   = o_frame_cnt;
            if (t == off_t) i_en = 1'b0;
            if (t == on_t)  i_en = 1'b1;
            if (t == pat_t) begin
                i_pat_sel   = npat;
                i_solid_rgb = nsolid;
            end
            tick();
        end
    endtask

    function automatic int count_de();
        int n = 0;
        for (int t = 0; t < FRAME; t++) n += int'(cap_de[t]);
        return n;
    endfunction

    task automatic test_reset();
        int errs = 0;
        rst = 1'b1; i_en = 1'b0; i_pat_sel = 2'd0; i_solid_rgb = '0;
        repeat (3) tick();
        checks++;
        if ({o_vsync, o_hsync, o_de, o_sof, o_busy, o_r_data, o_g_data, o_b_data, o_frame_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_values: got hs=%b vs=%b de=%b sof=%b busy=%b fc=%0d, expected all 0",
                     o_hsync, o_vsync, o_de, o_sof, o_busy, o_frame_cnt);
        end
        rst = 1'b0;
        repeat (50) begin
            tick();
            if ({o_vsync, o_hsync, o_de, o_sof, o_busy, o_r_data, o_g_data, o_b_data, o_frame_cnt} !== '0)
                errs++;
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL idle_50clk: %0d clocks with non-zero outputs, expected 0", errs);
        end
    endtask

    // Enable at cycle k; cycle k+1 still blank but busy; cycle k+2 is t=0.
    task automatic start_frame(input string name, input logic [1:0] pat);
        i_pat_sel = pat;
        i_en      = 1'b1;
        tick();
        checks++;
        if (o_hsync !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_k1: got hsync=%b busy=%b, expected hsync=0 busy=1", name, o_hsync, o_busy);
        end
        tick();
        checks++;
        if ({o_hsync, o_vsync, o_sof} !== 3'b111) begin
            failures++;
            $display("FAIL %s_k2: got hs/vs/sof=%b, expected 111", name, {o_hsync, o_vsync, o_sof});
        end
    endtask

    task automatic test_timing_ramp();
        int hs_e = 0, vs_e = 0, sof_e = 0, de_e = 0, px_e = 0, first = -1;
        logic [9:0] x;
        start_frame("start", 2'd1);
        // Pattern request changes to bars mid-frame: this frame stays a ramp
        walk_frame(-1, -1, 100, 2'd2, '0);
        for (int t = 0; t < FRAME; t++) begin
            if (cap_hs[t]  !== ((t % HTOT) == 0)) hs_e++;
            if (cap_vs[t]  !== (t < HTOT))        vs_e++;
            if (cap_sof[t] !== (t == 0))          sof_e++;
            if (cap_de[t]  !== exp_de(t))         de_e++;
            if (cap_de[t] === 1'b1 && first < 0)  first = t;
            x = 10'((t % HTOT) - 3);
            if (cap_rgb[t] !== (exp_de(t) ? {x, x, x} : 30'h0)) px_e++;
        end
        checks++; if (hs_e != 0)  begin failures++; $display("FAIL hsync_period15: %0d bad clocks, expected 0", hs_e); end
        checks++; if (vs_e != 0)  begin failures++; $display("FAIL vsync_15of165: %0d bad clocks, expected 0", vs_e); end
        checks++; if (sof_e != 0) begin failures++; $display("FAIL sof_pulse: %0d bad clocks, expected 0", sof_e); end
        checks++; if (de_e != 0)  begin failures++; $display("FAIL de_window: %0d bad clocks, expected 0", de_e); end
        checks++; if (first != 33) begin failures++; $display("FAIL first_de: got t=%0d, expected 33", first); end
        checks++; if (count_de() != 80) begin failures++; $display("FAIL de_count: got %0d, expected 80", count_de()); end
        checks++; if (px_e != 0)  begin failures++; $display("FAIL ramp_pixels: %0d bad clocks, expected 0", px_e); end
        checks++;
        if (cap_fc[163] !== 16'd0 || cap_fc[164] !== 16'd1) begin
            failures++;
            $display("FAIL frame_cnt_inc: got %0d->%0d, expected 0->1", cap_fc[163], cap_fc[164]);
        end
        checks++;
        if (o_sof !== 1'b1) begin failures++; $display("FAIL seamless_sof: got %b, expected 1", o_sof); end
    endtask

    task automatic test_patterns();
        int bar_e = 0, row0_e = 0, row2_e = 0, chk_e = 0;
        int x, y;
        walk_frame(-1, -1, 50, 2'd3, '0);
        for (int t = 0; t < FRAME; t++) begin
            x = (t % HTOT) - 3;
            if (exp_de(t)) begin
                if (cap_rgb[t] !== bar_exp[x]) bar_e++;
            end else if (cap_rgb[t] !== 30'h0) bar_e++;
        end
        checks++; if (bar_e != 0) begin failures++; $display("FAIL colour_bars: %0d bad clocks, expected 0", bar_e); end
        walk_frame(-1, -1, 50, 2'd1, '0);
        for (int t = 0; t < FRAME; t++) begin
            x = (t % HTOT) - 3;
            y = (t / HTOT) - 2;
            if (exp_de(t)) begin
                if (cap_rgb[t] !== ((chk_row0[x] ^ y[1]) ? WHITE : 30'h0)) begin
                    chk_e++;
                    if (y == 0) row0_e++;
                    if (y == 2) row2_e++;
                end
            end else if (cap_rgb[t] !== 30'h0) chk_e++;
        end
        checks++; if (row0_e != 0) begin failures++; $display("FAIL checker_row0: %0d bad pixels, expected 0", row0_e); end
        checks++; if (row2_e != 0) begin failures++; $display("FAIL checker_row2_inv: %0d bad pixels, expected 0", row2_e); end
        checks++; if (chk_e != 0)  begin failures++; $display("FAIL checker_frame: %0d bad clocks, expected 0", chk_e); end
    endtask

    task automatic test_pattern_change();
        int ramp_e = 0, solid_e = 0;
        logic [15:0] fc0;
        logic [9:0]  x;
        fc0 = o_frame_cnt;
        walk_frame(-1, -1, 60, 2'd0, SOLID);
        for (int t = 0; t < FRAME; t++) begin
            x = 10'((t % HTOT) - 3);
            if (cap_rgb[t] !== (exp_de(t) ? {x, x, x} : 30'h0)) ramp_e++;
        end
        checks++; if (ramp_e != 0) begin failures++; $display("FAIL change_kept_ramp: %0d bad clocks, expected 0", ramp_e); end
        checks++;
        if (o_frame_cnt !== fc0 + 16'd1) begin
            failures++; $display("FAIL frame_cnt_plus1: got %0d, expected %0d", o_frame_cnt, fc0 + 16'd1);
        end
        walk_frame(-1, -1, -1, 2'd0, SOLID);
        for (int t = 0; t < FRAME; t++)
            if (cap_rgb[t] !== (exp_de(t) ? SOLID : 30'h0)) solid_e++;
        checks++; if (solid_e != 0) begin failures++; $display("FAIL next_frame_solid: %0d bad clocks, expected 0", solid_e); end
        checks++;
        if (o_frame_cnt !== fc0 + 16'd2) begin
            failures++; $display("FAIL frame_cnt_plus2: got %0d, expected %0d", o_frame_cnt, fc0 + 16'd2);
        end
    endtask

    task automatic test_stop();
        int idle_e = 0;
        logic [15:0] fc0;
        fc0 = o_frame_cnt;
        walk_frame(40, -1, -1, 2'd0, SOLID);
        checks++; if (count_de() != 80) begin failures++; $display("FAIL stop_frame_completes: got %0d de, expected 80", count_de()); end
        checks++;
        if (cap_busy[163] !== 1'b1 || cap_busy[164] !== 1'b0) begin
            failures++; $display("FAIL stop_busy_edge: got %b%b, expected 10", cap_busy[163], cap_busy[164]);
        end
        checks++;
        if (o_frame_cnt !== fc0 + 16'd1) begin
            failures++; $display("FAIL stop_frame_cnt: got %0d, expected %0d", o_frame_cnt, fc0 + 16'd1);
        end
        repeat (30) begin
            if ({o_vsync, o_hsync, o_de, o_sof, o_busy, o_r_data, o_g_data, o_b_data} !== '0) idle_e++;
            tick();
        end
        checks++; if (idle_e != 0) begin failures++; $display("FAIL stop_idle: %0d non-idle clocks, expected 0", idle_e); end
    endtask

    task automatic test_stop_resume();
        int busy_e = 0;
        start_frame("resume_start", 2'd0);
        walk_frame(20, 80, -1, 2'd0, SOLID);
        for (int t = 0; t < FRAME; t++) if (cap_busy[t] !== 1'b1) busy_e++;
        checks++; if (busy_e != 0) begin failures++; $display("FAIL resume_busy: %0d low clocks, expected 0", busy_e); end
        checks++;
        if ({o_sof, o_vsync, o_hsync} !== 3'b111) begin
            failures++; $display("FAIL resume_no_gap: got sof/vs/hs=%b, expected 111", {o_sof, o_vsync, o_hsync});
        end
        walk_frame(-1, -1, -1, 2'd0, SOLID);
        checks++; if (count_de() != 80) begin failures++; $display("FAIL resume_next_frame: got %0d de, expected 80", count_de()); end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        repeat (40) tick();   // t=40: h=10, v=2 -> active pixel
        checks++; if (o_de !== 1'b1) begin failures++; $display("FAIL pre_reset_de: got %b, expected 1", o_de); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_vsync, o_hsync, o_de, o_sof, o_busy, o_r_data, o_g_data, o_b_data, o_frame_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset: got de=%b busy=%b rgb=%h fc=%0d, expected all 0",
                     o_de, o_busy, {o_r_data, o_g_data, o_b_data}, o_frame_cnt);
        end
        i_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        start_frame("restart", 2'd1);
        walk_frame(-1, -1, -1, 2'd1, '0);
        for (int t = 0; t < FRAME; t++) if (cap_de[t] === 1'b1 && first < 0) first = t;
        checks++; if (first != 33) begin failures++; $display("FAIL restart_first_de: got t=%0d, expected 33", first); end
        checks++; if (o_frame_cnt !== 16'd1) begin failures++; $display("FAIL restart_frame_cnt: got %0d, expected 1", o_frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_timing_ramp();
        test_patterns();
        test_pattern_change();
        test_stop();
        test_stop_resume();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
